// File: rtl/soc_rst_seq.sv
// Power-on reset sequencer: releases PLL, DDR, core and peripheral reset domains in order,
// gated by PLL-lock / DDR-init handshakes with timeouts, plus warm reset and error latching.
module soc_rst_seq #(
    parameter int PLL_RST_CYC = 240,
    parameter int STAGE_GAP   = 48,
    parameter int TIMEOUT     = 24000,
    parameter int CNT_W       = 16
) (
    input  logic       osc_clk,
    input  logic       sys_rstn,
    input  logic       pll_lock,
    input  logic       ddr_init_done,
    input  logic       soft_rst_req,
    output logic       pll_rstn,
    output logic       ddr_rstn,
    output logic       core_rstn,
    output logic       periph_rstn,
    output logic       seq_done,
    output logic       seq_err,
    output logic [1:0] err_code
);

    typedef enum logic [3:0] {
        S_PLL_RST,
        S_PLL_WAIT,
        S_DDR_REL,
        S_DDR_WAIT,
        S_CORE_REL,
        S_PERIPH_REL,
        S_RUN,
        S_WARM,
        S_ERR
    } state_t;

    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
    localparam logic [CNT_W-1:0] PLL_LAST  = CNT_W'(PLL_RST_CYC - 1);
    localparam logic [CNT_W-1:0] GAP_LAST  = CNT_W'(STAGE_GAP - 1);
    localparam logic [CNT_W-1:0] TO_LAST   = CNT_W'(TIMEOUT - 1);
    localparam logic [CNT_W-1:0] WARM_CORE = CNT_W'(STAGE_GAP - 1);
    localparam logic [CNT_W-1:0] WARM_DDR  = CNT_W'(2 * STAGE_GAP - 1);
    // The PLL is the fourth domain re-asserted, one more gap after DDR.
    localparam logic [CNT_W-1:0] WARM_END  = CNT_W'(3 * STAGE_GAP - 1);

    state_t           r_state;
    logic [CNT_W-1:0] r_cnt;
    logic             r_lock_lo;
    logic             r_pll_rstn;
    logic             r_ddr_rstn;
    logic             r_core_rstn;
    logic             r_periph_rstn;
    logic             r_seq_done;
    logic             r_seq_err;
    logic [1:0]       r_err_code;

    always_ff @(posedge osc_clk) begin
        if (!sys_rstn) begin
            r_state       <= S_PLL_RST;
            r_cnt         <= '0;
            r_lock_lo     <= 1'b0;
            r_pll_rstn    <= 1'b0;
            r_ddr_rstn    <= 1'b0;
            r_core_rstn   <= 1'b0;
            r_periph_rstn <= 1'b0;
            r_seq_done    <= 1'b0;
            r_seq_err     <= 1'b0;
            r_err_code    <= 2'b00;
        end else begin
            r_cnt     <= r_cnt + CNT_ONE;
            r_lock_lo <= 1'b0;
            case (r_state)
                S_PLL_RST: begin
                    if (r_cnt == PLL_LAST) begin
                        r_state    <= S_PLL_WAIT;
                        r_cnt      <= '0;
                        r_pll_rstn <= 1'b1;
                    end
                end
                S_PLL_WAIT: begin
                    if (pll_lock) begin
                        r_state <= S_DDR_REL;
                        r_cnt   <= '0;
                    end else if (r_cnt == TO_LAST) begin
                        r_state       <= S_ERR;
                        r_cnt         <= '0;
                        r_ddr_rstn    <= 1'b0;
                        r_core_rstn   <= 1'b0;
                        r_periph_rstn <= 1'b0;
                        r_seq_err     <= 1'b1;
                        r_err_code    <= 2'b01;
                    end
                end
                S_DDR_REL: begin
                    if (r_cnt == GAP_LAST) begin
                        r_state    <= S_DDR_WAIT;
                        r_cnt      <= '0;
                        r_ddr_rstn <= 1'b1;
                    end
                end
                S_DDR_WAIT: begin
                    if (ddr_init_done) begin
                        r_state <= S_CORE_REL;
                        r_cnt   <= '0;
                    end else if (r_cnt == TO_LAST) begin
                        r_state       <= S_ERR;
                        r_cnt         <= '0;
                        r_ddr_rstn    <= 1'b0;
                        r_core_rstn   <= 1'b0;
                        r_periph_rstn <= 1'b0;
                        r_seq_err     <= 1'b1;
                        r_err_code    <= 2'b10;
                    end
                end
                S_CORE_REL: begin
                    if (r_cnt == GAP_LAST) begin
                        r_state     <= S_PERIPH_REL;
                        r_cnt       <= '0;
                        r_core_rstn <= 1'b1;
                    end
                end
                S_PERIPH_REL: begin
                    if (r_cnt == GAP_LAST) begin
                        r_state       <= S_RUN;
                        r_cnt         <= '0;
                        r_periph_rstn <= 1'b1;
                        r_seq_done    <= 1'b1;
                    end
                end
                S_RUN: begin
                    // r_lock_lo remembers a low lock last cycle, so a one-cycle glitch is filtered.
                    if (!pll_lock && r_lock_lo) begin
                        r_state       <= S_ERR;
                        r_cnt         <= '0;
                        r_ddr_rstn    <= 1'b0;
                        r_core_rstn   <= 1'b0;
                        r_periph_rstn <= 1'b0;
                        r_seq_done    <= 1'b0;
                        r_seq_err     <= 1'b1;
                        r_err_code    <= 2'b11;
                    end else if (soft_rst_req) begin
                        r_state       <= S_WARM;
                        r_cnt         <= '0;
                        r_periph_rstn <= 1'b0;
                        r_seq_done    <= 1'b0;
                    end else begin
                        r_lock_lo <= !pll_lock;
                    end
                end
                S_WARM: begin
                    if (r_cnt == WARM_CORE) r_core_rstn <= 1'b0;
                    if (r_cnt == WARM_DDR)  r_ddr_rstn  <= 1'b0;
                    if (r_cnt == WARM_END) begin
                        r_state    <= S_PLL_RST;
                        r_cnt      <= '0;
                        r_pll_rstn <= 1'b0;
                        r_err_code <= 2'b00;
                    end
                end
                S_ERR: begin
                    if (soft_rst_req) begin
                        r_state    <= S_PLL_RST;
                        r_cnt      <= '0;
                        r_pll_rstn <= 1'b0;
                        r_seq_err  <= 1'b0;
                        r_err_code <= 2'b00;
                    end
                end
                default: begin
                    r_state <= S_PLL_RST;
                    r_cnt   <= '0;
                end
            endcase
        end
    end

    assign pll_rstn    = r_pll_rstn;
    assign ddr_rstn    = r_ddr_rstn;
    assign core_rstn   = r_core_rstn;
    assign periph_rstn = r_periph_rstn;
    assign seq_done    = r_seq_done;
    assign seq_err     = r_seq_err;
    assign err_code    = r_err_code;

endmodule

// File: tb/tb_soc_rst_seq.sv
// Bench for soc_rst_seq: milestone-timestamp model checked every cycle, plus literal edge checks.
module tb_soc_rst_seq;
    localparam int P = 4;
    localparam int G = 8;
    localparam int T = 64;

    logic       osc_clk       = 1'b0;
    logic       sys_rstn      = 1'b0;
    logic       pll_lock      = 1'b0;
    logic       ddr_init_done = 1'b0;
    logic       soft_rst_req  = 1'b0;
    logic       pll_rstn, ddr_rstn, core_rstn, periph_rstn, seq_done, seq_err;
    logic [1:0] err_code;

    int checks   = 0;
    int failures = 0;

    // Model: edge count plus the edge numbers of sequence milestones (-1 = not yet).
    int         n  = 0;
    int         t0 = 0;
    int         tl = -1;
    int         ti = -1;
    int         te = -1;
    int         tw = -1;
    logic [1:0] mcode   = 2'b00;
    bit         lo_prev = 1'b0;
    bit         run_chk = 1'b0;
    bit         merr;
    logic [7:0] exp_v, act_v;

    soc_rst_seq #(.PLL_RST_CYC(P), .STAGE_GAP(G), .TIMEOUT(T), .CNT_W(8)) dut (
        .osc_clk(osc_clk), .sys_rstn(sys_rstn), .pll_lock(pll_lock),
        .ddr_init_done(ddr_init_done), .soft_rst_req(soft_rst_req),
        .pll_rstn(pll_rstn), .ddr_rstn(ddr_rstn), .core_rstn(core_rstn),
        .periph_rstn(periph_rstn), .seq_done(seq_done), .seq_err(seq_err),
        .err_code(err_code)
    );

    always #5 osc_clk = ~osc_clk;

    // Milestones: t0 sequence origin, tl lock seen, ti init seen, te error, tw warm request.
    initial forever begin
        @(posedge osc_clk);
        n++;
        if (!sys_rstn) begin
            t0 = n; tl = -1; ti = -1; te = -1; tw = -1; mcode = 2'b00;
        end else if (te >= 0) begin
            if (soft_rst_req) begin
                t0 = n; tl = -1; ti = -1; te = -1; mcode = 2'b00;
            end
        end else if (tw >= 0) begin
            if (n == tw + 3 * G) begin
                t0 = n; tl = -1; ti = -1; tw = -1;
            end
        end else if (tl < 0) begin
            if (n > t0 + P) begin
                if (pll_lock) tl = n;
                else if (n == t0 + P + T) begin te = n; mcode = 2'b01; end
            end
        end else if (ti < 0) begin
            if (n > tl + G) begin
                if (ddr_init_done) ti = n;
                else if (n == tl + G + T) begin te = n; mcode = 2'b10; end
            end
        end else if (n > ti + 2 * G) begin
            if (!pll_lock && lo_prev) begin te = n; mcode = 2'b11; end
            else if (soft_rst_req) tw = n;
        end
        lo_prev = (ti >= 0 && te < 0 && tw < 0 && n > ti + 2 * G) ? !pll_lock : 1'b0;
    end

    initial forever begin
        @(negedge osc_clk);
        if (run_chk) begin
            merr  = (te >= 0);
            exp_v = {merr || (tw >= 0) || (n >= t0 + P),
                     !merr && (tl >= 0) && ((tw < 0) ? (n >= tl + G) : (n < tw + 2 * G)),
                     !merr && (ti >= 0) && ((tw < 0) ? (n >= ti + G) : (n < tw + G)),
                     !merr && (ti >= 0) && (tw < 0) && (n >= ti + 2 * G),
                     !merr && (ti >= 0) && (tw < 0) && (n >= ti + 2 * G),
                     merr, mcode};
            act_v = {pll_rstn, ddr_rstn, core_rstn, periph_rstn, seq_done, seq_err, err_code};
            checks++;
            if (act_v !== exp_v) begin
                failures++;
                $display("FAIL model edge=%0d got=%b want=%b", n, act_v, exp_v);
            end
        end
    end

    task automatic chk1(input string nm, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s edge=%0d got=%b want=%b", nm, n, act, exp);
        end
    endtask

    task automatic chk2(input string nm, input logic [1:0] act, input logic [1:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s edge=%0d got=%b want=%b", nm, n, act, exp);
        end
    endtask

    // Return at the falling edge that follows rising edge e.
    task automatic at(input int e);
        while (n < e) @(negedge osc_clk);
    endtask

    task automatic restart(output int b);
        sys_rstn = 1'b0;
        at(n + 2);
        b = n;
        sys_rstn = 1'b1;
    endtask

    initial begin
        int b;
        at(3);
        run_chk = 1'b1;
        chk1("rst_pll", pll_rstn, 1'b0);
        chk1("rst_ddr", ddr_rstn, 1'b0);
        chk1("rst_periph", periph_rstn, 1'b0);
        chk1("rst_done", seq_done, 1'b0);
        chk2("rst_code", err_code, 2'b00);

        // Nominal sequence, then lock glitch / lock loss, then soft recovery from ERR.
        b = n; sys_rstn = 1'b1;
        at(b + 3);  chk1("nom_pll_lo", pll_rstn, 1'b0);
        at(b + 4);  chk1("nom_pll_hi", pll_rstn, 1'b1);
        at(b + 10); pll_lock = 1'b1;
        at(b + 18); chk1("nom_ddr_lo", ddr_rstn, 1'b0);
        at(b + 19); chk1("nom_ddr_hi", ddr_rstn, 1'b1);
        at(b + 30); ddr_init_done = 1'b1;
        at(b + 38); chk1("nom_core_lo", core_rstn, 1'b0);
        at(b + 39); chk1("nom_core_hi", core_rstn, 1'b1);
        at(b + 46); chk1("nom_periph_lo", periph_rstn, 1'b0);
        at(b + 47); chk1("nom_periph_hi", periph_rstn, 1'b1); chk1("nom_done", seq_done, 1'b1);
        at(b + 60); pll_lock = 1'b0;
        at(b + 61); pll_lock = 1'b1;
        at(b + 70); chk1("glitch_done", seq_done, 1'b1); chk1("glitch_err", seq_err, 1'b0);
        at(b + 80); pll_lock = 1'b0;
        at(b + 81); chk1("loss_err_lo", seq_err, 1'b0);
        at(b + 82); chk1("loss_err_hi", seq_err, 1'b1); chk2("loss_code", err_code, 2'b11);
        chk1("loss_ddr", ddr_rstn, 1'b0); chk1("loss_core", core_rstn, 1'b0);
        chk1("loss_periph", periph_rstn, 1'b0); chk1("loss_pll", pll_rstn, 1'b1);
        at(b + 85); pll_lock = 1'b1; ddr_init_done = 1'b0;
        at(b + 90); soft_rst_req = 1'b1;
        at(b + 91); soft_rst_req = 1'b0;
        chk1("rec_pll", pll_rstn, 1'b0); chk1("rec_err", seq_err, 1'b0); chk2("rec_code", err_code, 2'b00);
        at(b + 104); chk1("rec_ddr", ddr_rstn, 1'b1);
        at(b + 110); ddr_init_done = 1'b1;
        at(b + 127); chk1("rec_done", seq_done, 1'b1);

        // Lock already high: 1-cycle PLL_WAIT; then warm reset from RUN.
        ddr_init_done = 1'b0;
        restart(b);
        at(b + 12); chk1("fast_ddr_lo", ddr_rstn, 1'b0);
        at(b + 13); chk1("fast_ddr_hi", ddr_rstn, 1'b1);
        at(b + 20); ddr_init_done = 1'b1;
        at(b + 37); chk1("warm_run", seq_done, 1'b1);
        at(b + 40); soft_rst_req = 1'b1;
        at(b + 41); soft_rst_req = 1'b0;
        chk1("warm_periph", periph_rstn, 1'b0); chk1("warm_core_hold", core_rstn, 1'b1);
        at(b + 48); chk1("warm_core_hi", core_rstn, 1'b1);
        at(b + 49); chk1("warm_core_lo", core_rstn, 1'b0); chk1("warm_ddr_hold", ddr_rstn, 1'b1);
        at(b + 57); chk1("warm_ddr_lo", ddr_rstn, 1'b0); chk1("warm_pll_hold", pll_rstn, 1'b1);
        at(b + 58); ddr_init_done = 1'b0;
        at(b + 64); chk1("warm_pll_hi", pll_rstn, 1'b1);
        at(b + 65); chk1("warm_pll_lo", pll_rstn, 1'b0);
        at(b + 80); ddr_init_done = 1'b1;
        at(b + 85); soft_rst_req = 1'b1;
        at(b + 86); soft_rst_req = 1'b0;
        at(b + 97); chk1("warm_rerun_done", seq_done, 1'b1);

        // PLL lock timeout.
        pll_lock = 1'b0; ddr_init_done = 1'b0;
        restart(b);
        at(b + 67); chk1("pto_err_lo", seq_err, 1'b0);
        at(b + 68); chk1("pto_err_hi", seq_err, 1'b1); chk2("pto_code", err_code, 2'b01);
        chk1("pto_ddr", ddr_rstn, 1'b0); chk1("pto_pll", pll_rstn, 1'b1);

        // Lock on the last timeout cycle wins; then DDR timeout and soft recovery.
        restart(b);
        at(b + 67); pll_lock = 1'b1;
        at(b + 68); chk1("late_lock_err", seq_err, 1'b0);
        at(b + 76); chk1("late_lock_ddr", ddr_rstn, 1'b1);
        at(b + 139); chk1("dto_err_lo", seq_err, 1'b0);
        at(b + 140); chk1("dto_err_hi", seq_err, 1'b1); chk2("dto_code", err_code, 2'b10);
        chk1("dto_ddr", ddr_rstn, 1'b0);
        at(b + 150); soft_rst_req = 1'b1;
        at(b + 151); soft_rst_req = 1'b0;
        chk2("dto_rec_code", err_code, 2'b00); chk1("dto_rec_pll", pll_rstn, 1'b0);
        at(b + 165); ddr_init_done = 1'b1;
        at(b + 182); chk1("dto_rec_done", seq_done, 1'b1);

        // sys_rstn during DDR_WAIT, coincident with a soft request.
        ddr_init_done = 1'b0;
        restart(b);
        at(b + 20); sys_rstn = 1'b0; soft_rst_req = 1'b1;
        at(b + 21); soft_rst_req = 1'b0;
        chk1("mid_pll", pll_rstn, 1'b0); chk1("mid_ddr", ddr_rstn, 1'b0);
        chk1("mid_err", seq_err, 1'b0); chk2("mid_code", err_code, 2'b00);
        at(b + 23); sys_rstn = 1'b1;
        at(b + 40);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
